riscv_mem_model_p: RTL

- Parametrised successor to the fixed 32-bit instruction/data memory interface used around RISC_V_lite in simulation.
- Provides separate instruction and data memories, each with its own base address and depth.
- Data reads have configurable wait-state latency with a valid/busy handshake.
- Includes a program-load port, address-error flagging and a sticky END_SIM detector based on PC stall.

---
 rtl/riscv_mem_model_p.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_model_p.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_model_p
// Purpose  : Parametrised instruction/data memory model for RISC-V cores in
//            simulation. Separate IMEM and DMEM with their own base/depth, a
//            wait-state data read path with valid/busy handshake, a program
//            load port, address-error flagging and a sticky END_SIM detector
//            driven by a stalled PC.
// Ports    : CLOCK/RESET        - clock, async active-high reset
//            PC / INSTRUCTION   - fetch address, registered fetched word
//            MEM_RD/MEM_WR/ADDRESS/WR_DATA - data request
//            RD_DATA/RD_VALID/BUSY - read response handshake
//            ADDR_ERR           - one-cycle pulse on any rejected request
//            LD_EN/LD_SEL/LD_IDX/LD_DATA - program-load port (0=IMEM,1=DMEM)
//            END_SIM            - sticky end-of-simulation flag
//            WR_BE              - byte strobes, only with WR_STROBE_EN
// Options  : `define WR_STROBE_EN adds WR_BE byte-enable writes on MEM_WR.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_model_p #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 32,
  parameter int                IMEM_DEPTH = 1024,
  parameter int                DMEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] IMEM_BASE  = ADDR_W'(32'h0040_0000),
  parameter logic [ADDR_W-1:0] DMEM_BASE  = ADDR_W'(32'h1001_0000),
  parameter int                RD_LATENCY = 1,   // 1..8
  parameter int                END_REPEAT = 4,
  localparam int MAX_DEPTH = (IMEM_DEPTH > DMEM_DEPTH) ? IMEM_DEPTH : DMEM_DEPTH,
  localparam int LD_IDX_W  = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [ADDR_W-1:0]   PC,
  output logic [DATA_W-1:0]   INSTRUCTION,
  input  logic                MEM_RD,
  input  logic                MEM_WR,
  input  logic [ADDR_W-1:0]   ADDRESS,
  input  logic [DATA_W-1:0]   WR_DATA,
`ifdef WR_STROBE_EN
  input  logic [DATA_W/8-1:0] WR_BE,
`endif
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID,
  output logic                BUSY,
  output logic                ADDR_ERR,
  input  logic                LD_EN,
  input  logic                LD_SEL,
  input  logic [LD_IDX_W-1:0] LD_IDX,
  input  logic [DATA_W-1:0]   LD_DATA,
  output logic                END_SIM
);

  localparam int NB       = DATA_W / 8;
  localparam int IMEM_AW  = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DMEM_AW  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int CNT_W    = $clog2(RD_LATENCY + 1);
  localparam int STALL_W  = $clog2(END_REPEAT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [DATA_W-1:0] imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  cap_q, cap_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [DATA_W-1:0]  instruction_q, instruction_d;
  logic               addr_err_q, addr_err_d;
  logic [ADDR_W-1:0]  pc_prev_q;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               end_sim_q, end_sim_d;

  // Address decode. Subtraction is unsigned, so an address below its base
  // wraps to a huge index and fails the range check on its own.
  logic [ADDR_W-1:0] pc_widx, d_widx;
  logic [31:0]       ld_idx_ext;
  logic              pc_ok, d_ok, ld_ok;

  always_comb begin
    pc_widx    = (PC - IMEM_BASE) >> 2;
    d_widx     = (ADDRESS - DMEM_BASE) >> 2;
    ld_idx_ext = 32'(LD_IDX);
    pc_ok      = (PC[1:0] == 2'b00) && (pc_widx < ADDR_W'(IMEM_DEPTH));
    d_ok       = (ADDRESS[1:0] == 2'b00) && (d_widx < ADDR_W'(DMEM_DEPTH));
    ld_ok      = LD_SEL ? (ld_idx_ext < 32'(DMEM_DEPTH))
                        : (ld_idx_ext < 32'(IMEM_DEPTH));
  end

  // Request classification; requests only count while IDLE.
  logic idle, req, both, bad_addr, rd_go, wr_acc, wr_go, ld_dmem_hit;
  logic imem_we, dmem_we;
  logic [DMEM_AW-1:0] dmem_widx;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [NB-1:0]      dmem_wmask, wr_mask;
  logic [DATA_W-1:0]  d_word;

  always_comb begin
    idle        = (state_q == S_IDLE);
    req         = MEM_RD | MEM_WR;
    both        = MEM_RD & MEM_WR;
    bad_addr    = idle & req & ~both & ~d_ok;
    rd_go       = idle & MEM_RD & ~MEM_WR & d_ok;
    wr_acc      = idle & MEM_WR & ~MEM_RD & d_ok;
    ld_dmem_hit = LD_EN & LD_SEL;
    // A DMEM load in the same cycle takes the write port; the CPU write loses.
    wr_go       = wr_acc & ~ld_dmem_hit;
    d_word      = dmem_q[d_widx[DMEM_AW-1:0]];
`ifdef WR_STROBE_EN
    wr_mask     = WR_BE;
`else
    wr_mask     = '1;
`endif
    imem_we     = LD_EN & ~LD_SEL & ld_ok;
    dmem_we     = (ld_dmem_hit & ld_ok) | wr_go;
    if (ld_dmem_hit) begin
      dmem_widx  = ld_idx_ext[DMEM_AW-1:0];
      dmem_wdata = LD_DATA;
      dmem_wmask = '1;
    end else begin
      dmem_widx  = d_widx[DMEM_AW-1:0];
      dmem_wdata = WR_DATA;
      dmem_wmask = wr_mask;
    end
    addr_err_d = ~pc_ok | (idle & both) | bad_addr | (LD_EN & ~ld_ok)
               | (wr_acc & ld_dmem_hit);
  end

  // Memory arrays: no reset, loaded through LD_* or MEM_WR.
  always_ff @(posedge CLOCK) begin
    if (imem_we) imem_q[ld_idx_ext[IMEM_AW-1:0]] <= LD_DATA;
    if (dmem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (dmem_wmask[b]) dmem_q[dmem_widx][b*8 +: 8] <= dmem_wdata[b*8 +: 8];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state. The wait counter is loaded with RD_LATENCY-1 so the
  // response lands exactly RD_LATENCY cycles after the request.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rd_go) begin
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = (RD_LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_d == '0) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    BUSY     = 1'b0;
    RD_VALID = 1'b0;
    case (state_q)
      S_WAIT:  BUSY     = 1'b1;
      S_RESP:  RD_VALID = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values. Read data is captured at request time so later
  // writes/loads cannot alter an in-flight read.
  always_comb begin
    cap_d         = rd_go ? d_word : cap_q;
    rd_data_d     = rd_data_q;
    if (rd_go && (RD_LATENCY == 1))                    rd_data_d = d_word;
    else if ((state_q == S_WAIT) && (state_d == S_RESP)) rd_data_d = cap_q;
    else if (bad_addr)                                 rd_data_d = '0;
    instruction_d = pc_ok ? imem_q[pc_widx[IMEM_AW-1:0]] : '0;
    if (PC == pc_prev_q)
      stall_cnt_d = (stall_cnt_q == STALL_W'(END_REPEAT)) ? stall_cnt_q
                                                           : stall_cnt_q + 1'b1;
    else
      stall_cnt_d = '0;
    end_sim_d     = end_sim_q | (stall_cnt_d == STALL_W'(END_REPEAT));
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      cap_q         <= '0;
      rd_data_q     <= '0;
      instruction_q <= '0;
      addr_err_q    <= 1'b0;
      pc_prev_q     <= '0;
      stall_cnt_q   <= '0;
      end_sim_q     <= 1'b0;
    end else begin
      cap_q         <= cap_d;
      rd_data_q     <= rd_data_d;
      instruction_q <= instruction_d;
      addr_err_q    <= addr_err_d;
      pc_prev_q     <= PC;
      stall_cnt_q   <= stall_cnt_d;
      end_sim_q     <= end_sim_d;
    end
  end

  assign INSTRUCTION = instruction_q;
  assign RD_DATA     = rd_data_q;
  assign ADDR_ERR    = addr_err_q;
  assign END_SIM     = end_sim_q;

endmodule
`default_nettype wire
